// File: rtl/mii_frame_checker_if.sv
// Receive-side bus of the MII frame checker. The byte/control stream flows in,
// and the checked payload, frame status and statistics flow out.
interface mii_frame_checker_if;
  logic [7:0]  i_rx_data;
  logic [7:0]  i_rx_ctrl;
  logic [7:0]  o_data;
  logic        o_data_valid;
  logic        o_frame_valid;
  logic        o_frame_error;
  logic [2:0]  o_err_code;
  logic [10:0] o_frame_len;
  logic [15:0] o_good_cnt;
  logic [15:0] o_err_cnt;

  // Source side: drives the received stream, observes checker results.
  modport master (
    output i_rx_data, i_rx_ctrl,
    input  o_data, o_data_valid, o_frame_valid, o_frame_error,
           o_err_code, o_frame_len, o_good_cnt, o_err_cnt
  );

  // Checker side.
  modport slave (
    input  i_rx_data, i_rx_ctrl,
    output o_data, o_data_valid, o_frame_valid, o_frame_error,
           o_err_code, o_frame_len, o_good_cnt, o_err_cnt
  );
endinterface

// File: rtl/mii_frame_checker.sv
// MII receive frame checker: validates START/preamble/SFD framing, forwards
// the post-SFD bytes with one cycle of latency, classifies the frame end
// (good, runt, oversize, unexpected control) and keeps good/bad counters.
module mii_frame_checker #(
  parameter int         PREAMBLE_CYCLES = 7,
  parameter int         MIN_FRAME_BYTES = 64,
  parameter int         MAX_FRAME_BYTES = 1518,
  parameter logic [7:0] IDLE_CODE       = 8'h07,
  parameter logic [7:0] START_CODE      = 8'hFB,
  parameter logic [7:0] PREAMBLE_CODE   = 8'h55,
  parameter logic [7:0] SFD_CODE        = 8'hD5,
  parameter logic [7:0] TERMINATE_CODE  = 8'hFD
) (
  input  logic              clk,
  input  logic              i_rst,
  mii_frame_checker_if.slave bus
);

  localparam int               PRE_W    = (PREAMBLE_CYCLES > 1) ? $clog2(PREAMBLE_CYCLES + 1) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_CYCLES - 1);
  localparam logic [10:0]      MIN_LEN  = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0]      MAX_LEN  = 11'(MAX_FRAME_BYTES);
  // One past the maximum is enough to tell "oversize" apart from any legal length.
  localparam logic [10:0]      LEN_SAT  = 11'(MAX_FRAME_BYTES + 1);

  localparam logic [2:0] ERR_PREAMBLE = 3'd1;
  localparam logic [2:0] ERR_NO_SFD   = 3'd2;
  localparam logic [2:0] ERR_RUNT     = 3'd3;
  localparam logic [2:0] ERR_OVERSIZE = 3'd4;
  localparam logic [2:0] ERR_CTRL     = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD_WAIT,
    DATA,
    DRAIN
  } state_t;

  function automatic logic [10:0] len_inc(input logic [10:0] v);
    return (v >= LEN_SAT) ? LEN_SAT : v + 11'd1;
  endfunction

  function automatic logic [15:0] cnt_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t           state, state_n;
  logic [PRE_W-1:0] pre_cnt, pre_cnt_n;
  logic [10:0]      len_cnt, len_cnt_n;

  logic             is_ctrl;
  logic             dvld_n, good_n, bad_n;
  logic [2:0]       code_n;
  logic [10:0]      flen_n;

  // Registered outputs, one cycle behind the input byte.
  logic [7:0]       data_p1;
  logic             vld_p1;
  logic             good_p1, bad_p1;
  logic [2:0]       err_code_q;
  logic [10:0]      frame_len_q;
  logic [15:0]      good_cnt_q, err_cnt_q;

  assign is_ctrl = |bus.i_rx_ctrl;

  // State register and framing counters.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= IDLE;
      pre_cnt <= '0;
      len_cnt <= '0;
    end else begin
      state   <= state_n;
      pre_cnt <= pre_cnt_n;
      len_cnt <= len_cnt_n;
    end
  end

  // Next-state decode and per-byte event strobes.
  always_comb begin
    state_n   = state;
    pre_cnt_n = pre_cnt;
    len_cnt_n = len_cnt;
    dvld_n    = 1'b0;
    good_n    = 1'b0;
    bad_n     = 1'b0;
    code_n    = 3'd0;
    flen_n    = frame_len_q;
    unique case (state)
      IDLE: begin
        if (is_ctrl && bus.i_rx_data == START_CODE) begin
          state_n   = PREAMBLE;
          pre_cnt_n = '0;
        end
      end
      PREAMBLE: begin
        if (!is_ctrl && bus.i_rx_data == PREAMBLE_CODE) begin
          pre_cnt_n = pre_cnt + 1'b1;
          if (pre_cnt == PRE_LAST) state_n = SFD_WAIT;
        end else begin
          bad_n   = 1'b1;
          code_n  = ERR_PREAMBLE;
          flen_n  = '0;
          state_n = DRAIN;
        end
      end
      SFD_WAIT: begin
        if (!is_ctrl && bus.i_rx_data == SFD_CODE) begin
          state_n   = DATA;
          len_cnt_n = '0;
        end else begin
          bad_n   = 1'b1;
          code_n  = ERR_NO_SFD;
          flen_n  = '0;
          state_n = DRAIN;
        end
      end
      DATA: begin
        if (!is_ctrl) begin
          dvld_n    = 1'b1;
          len_cnt_n = len_inc(len_cnt);
        end else if (bus.i_rx_data == TERMINATE_CODE) begin
          state_n = IDLE;
          flen_n  = len_cnt;
          if (len_cnt < MIN_LEN) begin
            bad_n  = 1'b1;
            code_n = ERR_RUNT;
          end else if (len_cnt > MAX_LEN) begin
            bad_n  = 1'b1;
            code_n = ERR_OVERSIZE;
          end else begin
            good_n = 1'b1;
          end
        end else begin
          // Any other control mid-frame, START included, aborts the frame.
          bad_n   = 1'b1;
          code_n  = ERR_CTRL;
          flen_n  = len_cnt;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (is_ctrl && (bus.i_rx_data == TERMINATE_CODE || bus.i_rx_data == IDLE_CODE))
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output stage: payload, pulses, sticky status and saturating counters.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      data_p1     <= '0;
      vld_p1      <= 1'b0;
      good_p1     <= 1'b0;
      bad_p1      <= 1'b0;
      err_code_q  <= '0;
      frame_len_q <= '0;
      good_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      vld_p1  <= dvld_n;
      good_p1 <= good_n;
      bad_p1  <= bad_n;
      if (dvld_n) data_p1 <= bus.i_rx_data;
      if (bad_n) begin
        err_code_q <= code_n;
        err_cnt_q  <= cnt_inc(err_cnt_q);
      end
      if (good_n) good_cnt_q <= cnt_inc(good_cnt_q);
      if (good_n || bad_n) frame_len_q <= flen_n;
    end
  end

  assign bus.o_data        = data_p1;
  assign bus.o_data_valid  = vld_p1;
  assign bus.o_frame_valid = good_p1;
  assign bus.o_frame_error = bad_p1;
  assign bus.o_err_code    = err_code_q;
  assign bus.o_frame_len   = frame_len_q;
  assign bus.o_good_cnt    = good_cnt_q;
  assign bus.o_err_cnt     = err_cnt_q;

endmodule
